// File: rtl/div_seq.sv
// Radix-2 restoring divider: latency 32 edges from the start edge (1 edge for a zero divisor).
// Backpressure: the result and ready_o are held for as long as start_i stays high; annul_i aborts in any state.
module div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] r, q, d;
   logic             neg_q, neg_r;

   logic [WIDTH:0]   t;
   logic [WIDTH-1:0] r_nxt, q_nxt;
   logic [WIDTH-1:0] abs1, abs2;
   logic             sign1, sign2;

   // One restoring step: trial-subtract the divisor from the shifted partial remainder.
   always_comb begin
      t     = {r, q[WIDTH-1]} - {1'b0, d};
      r_nxt = t[WIDTH] ? {r[WIDTH-2:0], q[WIDTH-1]} : t[WIDTH-1:0];
      q_nxt = {q[WIDTH-2:0], ~t[WIDTH]};
   end

   assign sign1 = signed_div_i & opdata1_i[WIDTH-1];
   assign sign2 = signed_div_i & opdata2_i[WIDTH-1];
   assign abs1  = sign1 ? -opdata1_i : opdata1_i;
   assign abs2  = sign2 ? -opdata2_i : opdata2_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_FREE;
         cnt      <= '0;
         r        <= '0;
         q        <= '0;
         d        <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else if (annul_i) begin
         state    <= S_FREE;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            S_FREE: begin
               if (start_i) begin
                  q     <= abs1;
                  d     <= abs2;
                  r     <= '0;
                  cnt   <= '0;
                  neg_q <= sign1 ^ sign2;
                  neg_r <= sign1;
                  state <= (opdata2_i == '0) ? S_BYZERO : S_ON;
               end
            end
            S_BYZERO: begin
               result_o <= '0;
               ready_o  <= 1'b1;
               state    <= S_END;
            end
            S_ON: begin
               r   <= r_nxt;
               q   <= q_nxt;
               cnt <= cnt + 1'b1;
               // Final step: publish the sign-corrected result straight from the next-state values.
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  result_o <= {(neg_r ? -r_nxt : r_nxt), (neg_q ? -q_nxt : q_nxt)};
                  ready_o  <= 1'b1;
                  state    <= S_END;
               end
            end
            S_END: begin
               if (!start_i) begin
                  result_o <= '0;
                  ready_o  <= 1'b0;
                  state    <= S_FREE;
               end
            end
            default: state <= S_FREE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed quotients/remainders, latency, hold, abort and async reset.
module tb_div_seq;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_chk  = 0;
   int n_pass = 0;

   div_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Count edges after the start edge until ready_o rises (0 if it never does).
   task automatic wait_ready(output int lat);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (ready_o) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic do_div(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r, input int exp_lat);
      int lat;
      @(negedge clk);
      signed_div_i = sg;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(posedge clk); #1;
      // Scramble operands after the start edge; the divider must use its latched copies.
      opdata1_i    = ~a;
      opdata2_i    = b + 32'd1;
      signed_div_i = ~sg;
      wait_ready(lat);
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_res"}, result_o, {exp_r, exp_q});
   endtask

   task automatic release_start(input string tag);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_rdy_clr"}, 64'(ready_o), 64'd0);
      chk({tag, "_res_clr"}, result_o, 64'd0);
   endtask

   initial begin
      int          lat;
      logic        seen;
      rst          = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      #12;
      chk("reset_rdy", 64'(ready_o), 64'd0);
      chk("reset_res", result_o, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Unsigned 100/7 with start held past ready
      do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32);
      repeat (3) @(posedge clk);
      #1;
      chk("u100_7_hold_rdy", 64'(ready_o), 64'd1);
      chk("u100_7_hold_res", result_o, {32'd2, 32'd14});
      release_start("u100_7");

      do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
      release_start("s_m7_2");
      do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 32);
      release_start("s_7_m2");
      do_div("s_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32);
      release_start("s_m7_m2");
      do_div("u_div0", 1'b0, 32'd1234, 32'd0, 32'd0, 32'd0, 1);
      release_start("u_div0");
      do_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32);
      release_start("u_max_1");
      do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32);
      release_start("s_ovf");
      do_div("u_m1_7", 1'b1, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF & 32'd0, 32'hFFFF_FFFF, 32);
      release_start("u_m1_7");

      // Annul at E10: no result, then a clean division must follow
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      annul_i = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen = seen | ready_o;
      end
      chk("annul_no_rdy", 64'(seen), 64'd0);
      chk("annul_res", result_o, 64'd0);
      do_div("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 32);
      release_start("u50_5");

      // Annul in FREE blocks a start on the same edge; division begins one edge later
      @(negedge clk);
      opdata1_i = 32'd50;
      opdata2_i = 32'd5;
      start_i   = 1'b1;
      annul_i   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      annul_i = 1'b0;
      wait_ready(lat);
      chk("annul_free_lat", 64'(lat), 64'd33);
      chk("annul_free_res", result_o, {32'd0, 32'd10});
      release_start("annul_free");

      // Async reset mid-ON
      @(negedge clk);
      opdata1_i = 32'd100;
      opdata2_i = 32'd7;
      start_i   = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_on_rdy", 64'(ready_o), 64'd0);
      chk("rst_on_res", result_o, 64'd0);
      @(negedge clk);
      rst     = 1'b0;
      start_i = 1'b0;

      // Async reset while a result is presented
      do_div("u9_2", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 32);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_end_rdy", 64'(ready_o), 64'd0);
      chk("rst_end_res", result_o, 64'd0);
      @(negedge clk);
      rst     = 1'b0;
      start_i = 1'b0;

      do_div("u7_3", 1'b0, 32'd7, 32'd3, 32'd2, 32'd1, 32);
      release_start("u7_3");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
